// File: rtl/cohort_mem_txn_unit.sv
// Cohort memory-transaction issue stage: buffers transactions in a FIFO, issues
// them one at a time to the memory port and returns in-order completions.

package config_pkg;
    localparam int unsigned PADDR_W = 40;
    localparam int unsigned SIZE_W  = 3;
    localparam int unsigned DATA_W  = 64;
    localparam int unsigned BE_W    = DATA_W / 8;

    typedef enum logic {T_LOAD = 1'b0, T_STORE = 1'b1} transaction_t;
    typedef logic [PADDR_W-1:0] paddr_t;
    typedef logic [SIZE_W-1:0]  size_t;
    typedef logic [DATA_W-1:0]  data_t;

    typedef struct packed {
        transaction_t typ;
        paddr_t       addr;
        size_t        size;
        data_t        data;
    } txn_t;
endpackage

module cohort_mem_txn_unit
    import config_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               txn_valid_i,
    output logic               txn_ready_o,
    input  logic               txn_type_i,
    input  logic [PADDR_W-1:0] txn_addr_i,
    input  logic [SIZE_W-1:0]  txn_size_i,
    input  logic [DATA_W-1:0]  txn_data_i,
    output logic               mem_req_valid_o,
    input  logic               mem_req_ready_i,
    output logic               mem_req_type_o,
    output logic [PADDR_W-1:0] mem_req_addr_o,
    output logic [BE_W-1:0]    mem_req_be_o,
    output logic [DATA_W-1:0]  mem_req_data_o,
    input  logic               mem_rsp_valid_i,
    input  logic [DATA_W-1:0]  mem_rsp_data_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_type_o,
    output logic [DATA_W-1:0]  rsp_data_o,
    output logic               rsp_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    // Byte lanes covered by an access of 2**size bytes starting at lane 0.
    function automatic logic [BE_W-1:0] size_lanes(input size_t size);
        case (size)
            3'd0:    return 8'h01;
            3'd1:    return 8'h03;
            3'd2:    return 8'h0F;
            3'd3:    return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic txn_illegal(input txn_t t);
        logic [2:0] amask;
        case (t.size)
            3'd0:    amask = 3'b000;
            3'd1:    amask = 3'b001;
            3'd2:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
        return (t.size > 3'd3) || ((t.addr[2:0] & amask) != 3'd0);
    endfunction

    state_t         r_state;
    txn_t           r_fifo [DEPTH];
    logic [AW-1:0]  r_wptr;
    logic [AW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           r_txn_ready;

    transaction_t   r_work_type;
    logic [2:0]     r_work_off;
    size_t          r_work_size;

    logic           r_mem_req_valid;
    transaction_t   r_mem_req_type;
    paddr_t         r_mem_req_addr;
    logic [BE_W-1:0] r_mem_req_be;
    data_t          r_mem_req_data;
    logic           r_rsp_valid;
    transaction_t   r_rsp_type;
    data_t          r_rsp_data;
    logic           r_rsp_err;

    txn_t           w_in;
    txn_t           w_head;
    logic           w_push;
    logic           w_pop;
    logic [2:0]     w_head_off;
    logic [CW-1:0]  w_count_nxt;
    logic [BE_W-1:0] w_work_lanes;
    data_t          w_load_mask;
    data_t          w_load_data;

    assign w_in       = {txn_type_i, txn_addr_i, txn_size_i, txn_data_i};
    assign w_head     = r_fifo[r_rptr];
    assign w_head_off = w_head.addr[2:0];
    assign w_push     = txn_valid_i & r_txn_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // Load alignment: bring the addressed lanes down to bit 0, then clear the rest.
    assign w_work_lanes = size_lanes(r_work_size);
    always_comb begin
        w_load_mask = '0;
        for (int i = 0; i < int'(BE_W); i++) begin
            w_load_mask[8*i +: 8] = {8{w_work_lanes[i]}};
        end
    end
    assign w_load_data = (mem_rsp_data_i >> {r_work_off, 3'b000}) & w_load_mask;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_in;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state         <= S_IDLE;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_count         <= '0;
            r_txn_ready     <= 1'b0;
            r_work_type     <= T_LOAD;
            r_work_off      <= '0;
            r_work_size     <= '0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_type  <= T_LOAD;
            r_mem_req_addr  <= '0;
            r_mem_req_be    <= '0;
            r_mem_req_data  <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_type      <= T_LOAD;
            r_rsp_data      <= '0;
            r_rsp_err       <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_txn_ready <= (w_count_nxt != CW'(DEPTH));
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_work_type <= w_head.typ;
                        r_work_off  <= w_head_off;
                        r_work_size <= w_head.size;
                        // Illegal transactions complete immediately without touching memory.
                        if (txn_illegal(w_head)) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_type  <= w_head.typ;
                            r_rsp_data  <= '0;
                            r_state     <= S_RESP;
                        end else begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_type  <= w_head.typ;
                            r_mem_req_addr  <= {w_head.addr[PADDR_W-1:3], 3'b000};
                            r_mem_req_be    <= BE_W'(size_lanes(w_head.size) << w_head_off);
                            r_mem_req_data  <= DATA_W'(w_head.data << {w_head_off, 3'b000});
                            r_state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rsp_valid_i) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_type  <= r_work_type;
                        r_rsp_data  <= (r_work_type == T_LOAD) ? w_load_data : '0;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign txn_ready_o     = r_txn_ready;
    assign mem_req_valid_o = r_mem_req_valid;
    assign mem_req_type_o  = r_mem_req_type;
    assign mem_req_addr_o  = r_mem_req_addr;
    assign mem_req_be_o    = r_mem_req_be;
    assign mem_req_data_o  = r_mem_req_data;
    assign rsp_valid_o     = r_rsp_valid;
    assign rsp_type_o      = r_rsp_type;
    assign rsp_data_o      = r_rsp_data;
    assign rsp_err_o       = r_rsp_err;

    // A memory response is only meaningful while a request is outstanding.
    a_rsp_only_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_valid_i |-> (r_state == S_WAIT));

endmodule

// File: tb/tb_cohort_mem_txn_unit.sv
// Self-checking bench for cohort_mem_txn_unit: directed and random transactions
// compared against a behavioural model of alignment, legality and ordering.

module tb_cohort_mem_txn_unit;
    import config_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        txn_valid;
    logic        txn_ready_o;
    logic        txn_type;
    logic [39:0] txn_addr;
    logic [2:0]  txn_size;
    logic [63:0] txn_data;
    logic        mem_req_valid_o;
    logic        mem_req_ready;
    logic        mem_req_type_o;
    logic [39:0] mem_req_addr_o;
    logic [7:0]  mem_req_be_o;
    logic [63:0] mem_req_data_o;
    logic        mem_rsp_valid;
    logic [63:0] mem_rsp_data;
    logic        rsp_valid_o;
    logic        rsp_ready;
    logic        rsp_type_o;
    logic [63:0] rsp_data_o;
    logic        rsp_err_o;

    int checks = 0;
    int errors = 0;

    cohort_mem_txn_unit #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .txn_valid_i     (txn_valid),
        .txn_ready_o     (txn_ready_o),
        .txn_type_i      (txn_type),
        .txn_addr_i      (txn_addr),
        .txn_size_i      (txn_size),
        .txn_data_i      (txn_data),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready),
        .mem_req_type_o  (mem_req_type_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_be_o    (mem_req_be_o),
        .mem_req_data_o  (mem_req_data_o),
        .mem_rsp_valid_i (mem_rsp_valid),
        .mem_rsp_data_i  (mem_rsp_data),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready),
        .rsp_type_o      (rsp_type_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_err_o       (rsp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic bit m_illegal(input logic [39:0] a, input logic [2:0] s);
        if (s > 3'd3) return 1'b1;
        return (a % (40'd1 << s)) != 40'd0;
    endfunction

    function automatic logic [7:0] m_be(input logic [39:0] a, input logic [2:0] s);
        int nb  = 1 << s;
        int off = int'(a[2:0]);
        return 8'(((1 << nb) - 1) << off);
    endfunction

    function automatic logic [63:0] m_wdata(input logic [39:0] a, input logic [63:0] d);
        return d << (8 * int'(a[2:0]));
    endfunction

    function automatic logic [63:0] m_rsp(input logic t, input logic [39:0] a,
                                          input logic [2:0] s, input logic [63:0] w);
        logic [63:0] v;
        int nb = 1 << s;
        if (m_illegal(a, s) || t == T_STORE) return 64'd0;
        v = w >> (8 * int'(a[2:0]));
        if (nb < 8) v = v & ((64'd1 << (8 * nb)) - 64'd1);
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic rand_txn(output logic t, output logic [39:0] a, output logic [2:0] s,
                            output logic [63:0] d, input bit allow_bad);
        t = 1'($urandom_range(0, 1));
        d = {$urandom, $urandom};
        a = 40'({$urandom, $urandom});
        s = 3'($urandom_range(0, 3));
        if (allow_bad && $urandom_range(0, 4) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
                s = 3'($urandom_range(4, 7));
            end else begin
                s = 3'($urandom_range(1, 3));
                a[0] = 1'b1;
            end
        end else begin
            a = a & ~((40'd1 << s) - 40'd1);
        end
    endtask

    task automatic present(input logic t, input logic [39:0] a, input logic [2:0] s,
                           input logic [63:0] d);
        txn_valid = 1'b1;
        txn_type  = t;
        txn_addr  = a;
        txn_size  = s;
        txn_data  = d;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        txn_valid     = 1'b0;
        txn_type      = 1'b0;
        txn_addr      = '0;
        txn_size      = '0;
        txn_data      = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        rsp_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [181:0] outs;
        rst_n = 1'b0; txn_valid = 1'b0; txn_type = 1'b0; txn_addr = '0; txn_size = '0;
        txn_data = '0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        rsp_ready = 1'b0;
        #1;
        outs = {txn_ready_o, mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_be_o,
                mem_req_data_o, rsp_valid_o, rsp_type_o, rsp_data_o, rsp_err_o};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk) #1;
        checks++;
        if ({txn_ready_o, mem_req_valid_o, rsp_valid_o} !== 3'b100) begin
            errors++;
            $display("FAIL reset_release: ready/req/rsp got %b expected 100",
                     {txn_ready_o, mem_req_valid_o, rsp_valid_o});
        end
    endtask

    // Directed spec cases first, then random legal/illegal single transactions.
    task automatic test_single_txns();
        logic        t;
        logic [39:0] a;
        logic [2:0]  s;
        logic [63:0] d, w, exp_rsp;
        logic [7:0]  exp_be;
        logic [113:0] got_req, exp_req;
        bit          bad;
        int          n;
        for (int i = 0; i < 40; i++) begin
            w = {$urandom, $urandom};
            case (i)
                0: begin t = T_LOAD;  a = 40'h00_1000_0004; s = 3'd2; d = '0;
                         w = 64'hAABBCCDD_11223344; end
                1: begin t = T_STORE; a = 40'h23; s = 3'd0; d = 64'h5A; end
                2: begin t = T_LOAD;  a = 40'h06; s = 3'd2; d = '0; end
                3: begin t = T_STORE; a = 40'h40; s = 3'd4; d = {$urandom, $urandom}; end
                default: rand_txn(t, a, s, d, 1'b1);
            endcase
            bad     = m_illegal(a, s);
            exp_rsp = m_rsp(t, a, s, w);
            exp_be  = m_be(a, s);
            checks++;
            if (txn_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL single[%0d] ready_idle: got %b expected 1", i, txn_ready_o);
            end
            present(t, a, s, d);
            @(posedge clk) #1;
            txn_valid = 1'b0;
            @(posedge clk) #1;
            if (bad) begin
                checks++;
                if ({mem_req_valid_o, rsp_valid_o, rsp_err_o, rsp_type_o, rsp_data_o} !==
                    {1'b0, 1'b1, 1'b1, t, 64'd0}) begin
                    errors++;
                    $display("FAIL single[%0d] illegal_rsp: req_v=%b v=%b err=%b type=%b data=%h expected 0 1 1 %b 0",
                             i, mem_req_valid_o, rsp_valid_o, rsp_err_o, rsp_type_o, rsp_data_o, t);
                end
            end else begin
                exp_req = {1'b1, t, a & ~40'd7, exp_be, m_wdata(a, d)};
                n = $urandom_range(0, 3);
                for (int k = 0; k <= n; k++) begin
                    got_req = {mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_be_o,
                               mem_req_data_o};
                    checks++;
                    if (got_req !== exp_req) begin
                        errors++;
                        $display("FAIL single[%0d] mem_req cyc%0d: got %h expected %h",
                                 i, k, got_req, exp_req);
                    end
                    if (k < n) @(posedge clk) #1;
                end
                mem_req_ready = 1'b1;
                @(posedge clk) #1;
                mem_req_ready = 1'b0;
                checks++;
                if ({mem_req_valid_o, rsp_valid_o} !== 2'b00) begin
                    errors++;
                    $display("FAIL single[%0d] wait_state: req_v/rsp_v got %b expected 00",
                             i, {mem_req_valid_o, rsp_valid_o});
                end
                repeat ($urandom_range(0, 2)) @(posedge clk) #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = w;
                @(posedge clk) #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = {$urandom, $urandom};
                checks++;
                if ({rsp_valid_o, rsp_err_o, rsp_type_o, rsp_data_o} !== {1'b1, 1'b0, t, exp_rsp}) begin
                    errors++;
                    $display("FAIL single[%0d] rsp: v=%b err=%b type=%b data=%h expected 1 0 %b %h",
                             i, rsp_valid_o, rsp_err_o, rsp_type_o, rsp_data_o, t, exp_rsp);
                end
            end
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                @(posedge clk) #1;
                checks++;
                if ({rsp_valid_o, rsp_err_o, rsp_data_o, mem_req_valid_o} !== {1'b1, bad, exp_rsp, 1'b0}) begin
                    errors++;
                    $display("FAIL single[%0d] rsp_hold: v=%b err=%b data=%h req_v=%b expected 1 %b %h 0",
                             i, rsp_valid_o, rsp_err_o, rsp_data_o, mem_req_valid_o, bad, exp_rsp);
                end
            end
            rsp_ready = 1'b1;
            @(posedge clk) #1;
            rsp_ready = 1'b0;
            checks++;
            if (rsp_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL single[%0d] rsp_drop: got %b expected 0", i, rsp_valid_o);
            end
        end
    endtask

    // Fill working register + FIFO with the back end stalled, then drain in order.
    task automatic test_full_order();
        logic        t;
        logic [39:0] a;
        logic [2:0]  s;
        logic [63:0] d, w, exp_rsp;
        logic        qt [$];
        logic [39:0] qa [$];
        logic [2:0]  qs [$];
        int          acc = 0;
        bit          take;
        apply_reset();
        rand_txn(t, a, s, d, 1'b0);
        present(t, a, s, d);
        for (int c = 0; c < 3 * int'(DEPTH) + 4; c++) begin
            take = txn_ready_o;
            @(posedge clk) #1;
            if (take) begin
                qt.push_back(t); qa.push_back(a); qs.push_back(s);
                acc++;
                rand_txn(t, a, s, d, 1'b0);
                present(t, a, s, d);
            end
        end
        txn_valid = 1'b0;
        checks++;
        if (acc != int'(DEPTH) + 1 || txn_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL full_accepts: accepted %0d ready=%b expected %0d and 0",
                     acc, txn_ready_o, DEPTH + 1);
        end
        while (qa.size() > 0) begin
            t = qt.pop_front(); a = qa.pop_front(); s = qs.pop_front();
            for (int k = 0; k < 8 && mem_req_valid_o !== 1'b1; k++) @(posedge clk) #1;
            checks++;
            if ({mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_be_o} !==
                {1'b1, t, a & ~40'd7, m_be(a, s)}) begin
                errors++;
                $display("FAIL full_order req: v=%b type=%b addr=%h be=%h expected 1 %b %h %h",
                         mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_be_o,
                         t, a & ~40'd7, m_be(a, s));
                apply_reset();
                return;
            end
            mem_req_ready = 1'b1;
            @(posedge clk) #1;
            mem_req_ready = 1'b0;
            w = {$urandom, $urandom};
            exp_rsp = m_rsp(t, a, s, w);
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = w;
            @(posedge clk) #1;
            mem_rsp_valid = 1'b0;
            checks++;
            if ({rsp_valid_o, rsp_type_o, rsp_data_o} !== {1'b1, t, exp_rsp}) begin
                errors++;
                $display("FAIL full_order rsp: v=%b type=%b data=%h expected 1 %b %h",
                         rsp_valid_o, rsp_type_o, rsp_data_o, t, exp_rsp);
            end
            rsp_ready = 1'b1;
            @(posedge clk) #1;
            rsp_ready = 1'b0;
        end
        checks++;
        if (txn_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL full_drained_ready: got %b expected 1", txn_ready_o);
        end
    endtask

    // Back-pressure on both ports with a second transaction waiting behind.
    task automatic test_stall();
        logic        ta, tb;
        logic [39:0] aa, ab;
        logic [2:0]  sa, sb;
        logic [63:0] da, db, w, exp_rsp;
        logic [113:0] exp_req, got_req;
        apply_reset();
        rand_txn(ta, aa, sa, da, 1'b0);
        rand_txn(tb, ab, sb, db, 1'b0);
        present(ta, aa, sa, da);
        @(posedge clk) #1;
        present(tb, ab, sb, db);
        @(posedge clk) #1;
        txn_valid = 1'b0;
        exp_req = {1'b1, ta, aa & ~40'd7, m_be(aa, sa), m_wdata(aa, da)};
        for (int k = 0; k < 4; k++) begin
            got_req = {mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_be_o, mem_req_data_o};
            checks++;
            if (got_req !== exp_req) begin
                errors++;
                $display("FAIL stall_req cyc%0d: got %h expected %h", k, got_req, exp_req);
            end
            if (k < 3) @(posedge clk) #1;
        end
        mem_req_ready = 1'b1;
        @(posedge clk) #1;
        mem_req_ready = 1'b0;
        w = {$urandom, $urandom};
        exp_rsp = m_rsp(ta, aa, sa, w);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = w;
        @(posedge clk) #1;
        mem_rsp_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({rsp_valid_o, rsp_type_o, rsp_err_o, rsp_data_o, mem_req_valid_o} !==
                {1'b1, ta, 1'b0, exp_rsp, 1'b0}) begin
                errors++;
                $display("FAIL stall_rsp cyc%0d: v=%b type=%b err=%b data=%h req_v=%b expected 1 %b 0 %h 0",
                         k, rsp_valid_o, rsp_type_o, rsp_err_o, rsp_data_o, mem_req_valid_o, ta, exp_rsp);
            end
            if (k < 3) @(posedge clk) #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk) #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid_o, mem_req_valid_o} !== 2'b00) begin
            errors++;
            $display("FAIL stall_gap: rsp_v/req_v got %b expected 00", {rsp_valid_o, mem_req_valid_o});
        end
        @(posedge clk) #1;
        exp_req = {1'b1, tb, ab & ~40'd7, m_be(ab, sb), m_wdata(ab, db)};
        got_req = {mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_be_o, mem_req_data_o};
        checks++;
        if (got_req !== exp_req) begin
            errors++;
            $display("FAIL stall_second_req: got %h expected %h", got_req, exp_req);
        end
        mem_req_ready = 1'b1;
        @(posedge clk) #1;
        mem_req_ready = 1'b0;
        w = {$urandom, $urandom};
        exp_rsp = m_rsp(tb, ab, sb, w);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = w;
        @(posedge clk) #1;
        mem_rsp_valid = 1'b0;
        checks++;
        if ({rsp_valid_o, rsp_type_o, rsp_data_o} !== {1'b1, tb, exp_rsp}) begin
            errors++;
            $display("FAIL stall_second_rsp: v=%b type=%b data=%h expected 1 %b %h",
                     rsp_valid_o, rsp_type_o, rsp_data_o, tb, exp_rsp);
        end
        rsp_ready = 1'b1;
        @(posedge clk) #1;
        rsp_ready = 1'b0;
    endtask

    // Reset while a request is outstanding and two more are queued.
    task automatic test_reset_in_wait();
        logic        t;
        logic [39:0] a;
        logic [2:0]  s;
        logic [63:0] d;
        logic [181:0] outs;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            rand_txn(t, a, s, d, 1'b0);
            present(t, a, s, d);
            @(posedge clk) #1;
        end
        txn_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk) #1;
        mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        outs = {txn_ready_o, mem_req_valid_o, mem_req_type_o, mem_req_addr_o, mem_req_be_o,
                mem_req_data_o, rsp_valid_o, rsp_type_o, rsp_data_o, rsp_err_o};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_in_wait outputs: got %h expected 0", outs);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk) #1;
        checks++;
        if (txn_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_wait ready: got %b expected 1", txn_ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk) #1;
            checks++;
            if ({mem_req_valid_o, rsp_valid_o} !== 2'b00) begin
                errors++;
                $display("FAIL reset_in_wait empty cyc%0d: req_v/rsp_v got %b expected 00",
                         k, {mem_req_valid_o, rsp_valid_o});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_txns();
        test_full_order();
        test_stall();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
